// File: rtl/riscv_pkg.sv
// Shared load/store definitions: funct3 size codes, LSU FSM encoding, lane widths.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LANES = 4;
    localparam int BE_W  = LANES;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables, store replication, load extraction/extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr,
    input  logic [31:0]     i_wdata,
    input  logic [31:0]     i_rdata,
    output logic [BE_W-1:0] o_be,
    output logic [31:0]     o_wdata,
    output logic [31:0]     o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Misaligned halves/words just drop the low address bits here
    assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr[1], 4'b0000} +: 16];

    always_comb begin
        o_be    = '0;
        o_wdata = i_wdata;
        unique case (i_funct3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_addr;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_be    = 4'b0011 << {i_addr[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
            end
            2'b10: o_be = 4'b1111;
            default: o_be = '0;
        endcase
    end

    always_comb begin
        o_rdata = i_rdata;
        unique case (i_funct3)
            F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_rdata = {24'd0, w_byte};
            F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
            F3_HU:   o_rdata = {16'd0, w_half};
            default: o_rdata = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with bus timeout.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned H/W accesses.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            memread,
    input  logic            memwrite,
    input  logic [2:0]      funct3,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [31:0]     mem_addr,
    output logic [BE_W-1:0] mem_be,
    output logic [31:0]     mem_wdata,
    input  logic            mem_ack,
    input  logic [31:0]     mem_rdata,
    output logic            resp_valid,
    output logic [31:0]     resp_data,
    output logic            resp_err
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    lsu_state_t  r_state, w_next;
    logic        r_rd, r_wr, r_err;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [7:0]  r_cnt;

    logic            w_illegal, w_misalign, w_tmo;
    logic [BE_W-1:0] w_be;
    logic [31:0]     w_ld;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((funct3[1:0] == 2'b01) && addr[0])
                     || ((funct3 == F3_W) && (addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Stores only come in B/H/W; unsigned codes are load-only
    assign w_illegal = (memread == memwrite)
                    || (funct3 == 3'b011) || (funct3[2:1] == 2'b11)
                    || (memwrite && funct3[2])
                    || w_misalign;

    assign w_tmo = (r_cnt == TO_LAST);

    lsu_align u_align (
        .i_funct3 (r_f3),
        .i_addr   (r_addr[1:0]),
        .i_wdata  (r_wdata),
        .i_rdata  (r_rdata),
        .o_be     (w_be),
        .o_wdata  (mem_wdata),
        .o_rdata  (w_ld)
    );

    assign mem_addr = {r_addr[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (req_valid) w_next = w_illegal ? S_RESP : S_BUS;
            S_BUS:   if (mem_ack || w_tmo) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == S_IDLE);
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_be     = '0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_data  = '0;
        unique case (r_state)
            S_BUS: begin
                mem_req = 1'b1;
                mem_we  = r_wr;
                mem_be  = w_be;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                resp_data  = (r_rd && !r_err) ? w_ld : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
            r_f3    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: if (req_valid) begin
                    r_rd    <= memread;
                    r_wr    <= memwrite;
                    r_f3    <= funct3;
                    r_addr  <= addr;
                    r_wdata <= wdata;
                    r_err   <= w_illegal;
                    r_cnt   <= '0;
                end
                S_BUS: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (mem_ack)    r_rdata <= mem_rdata;
                    else if (w_tmo) r_err   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit (TIMEOUT=4).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        memread = 1'b0;
    logic        memwrite = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_data;

    int n_vec = 0;
    int n_bad = 0;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .memread(memread), .memwrite(memwrite),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .resp_valid(resp_valid),
        .resp_data(resp_data), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
        chk("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        memread   = rd;
        memwrite  = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        tick();
        req_valid = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        funct3    = '0;
        addr      = 32'hFFFF_FFFF;
        wdata     = 32'hFFFF_FFFF;
    endtask

    // Currently in BUS: hold for waits cycles, then ack; ends in RESP
    task automatic bus(input int waits, input logic [31:0] rd);
        for (int i = 0; i < waits; i++) begin
            chk("req_held", 32'(mem_req), 32'd1);
            tick();
        end
        chk("req_at_ack", 32'(mem_req), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h5A5A_5A5A;
    endtask

    task automatic resp(input string tag, input logic [31:0] d,
                        input logic e);
        chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_data"}, resp_data, d);
        chk({tag, "_err"}, 32'(resp_err), 32'(e));
        tick();
        chk({tag, "_pulse"}, 32'(resp_valid), 32'd0);
        chk({tag, "_idle"}, 32'(req_ready), 32'd1);
    endtask

    task automatic load(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] rd,
                        input logic [3:0] be, input logic [31:0] exp);
        send(1'b1, 1'b0, f3, a, 32'h0);
        chk({tag, "_be"}, 32'(mem_be), 32'(be));
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        bus(0, rd);
        resp(tag, exp, 1'b0);
    endtask

    task automatic illegal(input string tag, input logic rd,
                           input logic wr, input logic [2:0] f3,
                           input logic [31:0] a);
        send(rd, wr, f3, a, 32'h1111_2222);
        chk({tag, "_noreq"}, 32'(mem_req), 32'd0);
        resp(tag, 32'h0, 1'b1);
    endtask

    initial begin
        int n;
        #12;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_data", resp_data, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("rel_ready", 32'(req_ready), 32'd1);

        // LW with two wait states
        send(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        chk("lw_addr", mem_addr, 32'h10);
        chk("lw_be", 32'(mem_be), 32'hF);
        chk("lw_ready_busy", 32'(req_ready), 32'd0);
        bus(2, 32'hDEAD_BEEF);
        resp("lw", 32'hDEAD_BEEF, 1'b0);

        load("lb", 3'b000, 32'h13, 32'h80FF_0011, 4'b1000, 32'hFFFF_FF80);
        load("lbu", 3'b100, 32'h13, 32'h80FF_0011, 4'b1000, 32'h0000_0080);
        load("lh", 3'b001, 32'h22, 32'h8001_0000, 4'b1100, 32'hFFFF_8001);
        load("lhu", 3'b101, 32'h20, 32'h0000_F00F, 4'b0011, 32'h0000_F00F);
        load("lb1", 3'b000, 32'h01, 32'h0000_7F00, 4'b0010, 32'h0000_007F);

        // SH: replicated half, upper lanes
        send(1'b0, 1'b1, 3'b001, 32'h06, 32'h1234_ABCD);
        chk("sh_we", 32'(mem_we), 32'd1);
        chk("sh_be", 32'(mem_be), 32'hC);
        chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        chk("sh_addr", mem_addr, 32'h04);
        bus(1, 32'hFFFF_FFFF);
        resp("sh", 32'h0, 1'b0);

        send(1'b0, 1'b1, 3'b000, 32'h101, 32'h0000_0055);
        chk("sb_be", 32'(mem_be), 32'h2);
        chk("sb_wdata", mem_wdata, 32'h5555_5555);
        bus(0, 32'h0);
        resp("sb", 32'h0, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
        illegal("lw_mis", 1'b1, 1'b0, 3'b010, 32'h21);
`else
        send(1'b1, 1'b0, 3'b010, 32'h21, 32'h0);
        chk("lw_mis_addr", mem_addr, 32'h20);
        chk("lw_mis_be", 32'(mem_be), 32'hF);
        bus(0, 32'hCAFE_F00D);
        resp("lw_mis", 32'hCAFE_F00D, 1'b0);
`endif

        illegal("ill_rw", 1'b1, 1'b1, 3'b010, 32'h0);
        illegal("ill_none", 1'b0, 1'b0, 3'b010, 32'h0);
        illegal("ill_f3", 1'b1, 1'b0, 3'b011, 32'h0);
        illegal("ill_sbu", 1'b0, 1'b1, 3'b100, 32'h0);

        // Stray ack while idle must not produce anything
        mem_ack = 1'b1;
        tick();
        tick();
        mem_ack = 1'b0;
        chk("stray_ack_valid", 32'(resp_valid), 32'd0);
        chk("stray_ack_ready", 32'(req_ready), 32'd1);

        // Timeout: no ack ever
        send(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        n = 0;
        while (mem_req && n < 20) begin
            n++;
            tick();
        end
        chk("tmo_cycles", 32'(n), 32'd4);
        resp("tmo", 32'h0, 1'b1);

        // Reset in BUS abandons the access
        send(1'b1, 1'b0, 3'b010, 32'h80, 32'h0);
        chk("rbus_req", 32'(mem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rbus_async_req", 32'(mem_req), 32'd0);
        tick();
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (resp_valid) n++;
        end
        chk("rbus_no_resp", 32'(n), 32'd0);
        send(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
        chk("rbus_lw_addr", mem_addr, 32'h0);
        bus(0, 32'h0123_4567);
        resp("rbus_lw", 32'h0123_4567, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
